// File: rtl/arch_defines.sv
// rtl/arch_defines.sv - shared architectural constants: arbiter states, requester ids, size_and_sign codes
package arch_defines;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam logic [2:0] LOAD_BYTE   = 3'b000;
  localparam logic [2:0] LOAD_HALF   = 3'b001;
  localparam logic [2:0] LOAD_WORD   = 3'b010;
  localparam logic [2:0] LOAD_BYTE_U = 3'b100;
  localparam logic [2:0] LOAD_HALF_U = 3'b101;

  localparam logic [2:0] STORE_BYTE  = 3'b000;
  localparam logic [2:0] STORE_HALF  = 3'b001;
  localparam logic [2:0] STORE_WORD  = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request-response channels plus the shared RAM port
interface mem_arbiter_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_size;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  logic [31:0] mem_read_address;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_size_and_sign;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  if_req_valid, if_addr, if_rsp_ready,
    input  d_req_valid, d_we, d_addr, d_wdata, d_size, d_rsp_ready,
    input  mem_read_data,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_read_address, mem_write_address, mem_write_data,
    output mem_size_and_sign, mem_write_enable
  );

  modport master (
    output if_req_valid, if_addr, if_rsp_ready,
    output d_req_valid, d_we, d_addr, d_wdata, d_size, d_rsp_ready,
    output mem_read_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_read_address, mem_write_address, mem_write_data,
    input  mem_size_and_sign, mem_write_enable
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant between fetch and data requesters
module rr_arbiter2
  import arch_defines::*;
(
  input  logic fetch_valid_i,
  input  logic data_valid_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  always_comb begin
    grant_valid_o = fetch_valid_i | data_valid_i;
    grant_id_o    = REQ_FETCH;
    // On conflict the requester that lost last time wins.
    if (fetch_valid_i && data_valid_i) begin
      grant_id_o = (last_grant_i == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (data_valid_i) begin
      grant_id_o = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port RAM between instruction fetch and data requesters
module mem_arbiter
  import arch_defines::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [31:0] MAX_ADDR = 32'(4 * DEPTH - 4);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        id_q, id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic grant_valid;
  logic grant_id;
  logic addr_legal;
  logic rsp_ready_sel;

  rr_arbiter2 u_rr (
    .fetch_valid_i (bus.if_req_valid),
    .data_valid_i  (bus.d_req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Word-aligned bound applies to every access size.
  assign addr_legal    = (addr_q <= MAX_ADDR);
  assign rsp_ready_sel = (id_q == REQ_DATA) ? bus.d_rsp_ready : bus.if_rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      id_q         <= REQ_FETCH;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      we_q         <= we_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    size_d           = size_q;
    we_d             = we_q;
    id_d             = id_q;
    rsp_data_d       = rsp_data_q;
    rsp_err_d        = rsp_err_q;
    bus.if_req_ready = 1'b0;
    bus.d_req_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !reset) begin
          state_d      = ST_ACCESS;
          last_grant_d = grant_id;
          id_d         = grant_id;
          if (grant_id == REQ_DATA) begin
            bus.d_req_ready = 1'b1;
            addr_d          = bus.d_addr;
            wdata_d         = bus.d_wdata;
            size_d          = bus.d_size;
            we_d            = bus.d_we;
          end else begin
            bus.if_req_ready = 1'b1;
            addr_d           = bus.if_addr;
            wdata_d          = '0;
            size_d           = LOAD_WORD;
            we_d             = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        state_d    = ST_RESP;
        rsp_err_d  = !addr_legal;
        rsp_data_d = (we_q || !addr_legal) ? 32'h0 : bus.mem_read_data;
      end
      ST_RESP: begin
        if (rsp_ready_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_read_address  = addr_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = wdata_q;
  assign bus.mem_size_and_sign = size_q;
  assign bus.mem_write_enable  = (state_q == ST_ACCESS) && we_q && addr_legal && !reset;

  assign bus.if_rsp_valid = (state_q == ST_RESP) && (id_q == REQ_FETCH);
  assign bus.d_rsp_valid  = (state_q == ST_RESP) && (id_q == REQ_DATA);
  assign bus.if_rsp_data  = rsp_data_q;
  assign bus.d_rsp_data   = rsp_data_q;
  assign bus.if_rsp_err   = rsp_err_q;
  assign bus.d_rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random checks of mem_arbiter against a word-array reference model
module tb_mem_arbiter;
  import arch_defines::*;

  localparam int unsigned DEPTH = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   we_cnt = 0;
  bit   ram_ready = 1'b0;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] bg(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input logic [2:0] sz);
    logic [31:0] w;
    w = old;
    case (sz)
      STORE_BYTE: w[{a[1:0], 3'b000} +: 8]  = d[7:0];
      STORE_HALF: w[{a[1], 4'b0000} +: 16] = d[15:0];
      default:    w = d;
    endcase
    return w;
  endfunction

  // Environment RAM: out-of-range reads return junk so the arbiter must zero them.
  assign bus.mem_read_data = (bus.mem_read_address < 32'(4 * DEPTH))
                           ? ram[bus.mem_read_address[11:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= bg(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_write_enable) begin
      ram[bus.mem_write_address[11:2]] <= ram_merge(ram[bus.mem_write_address[11:2]],
          bus.mem_write_address, bus.mem_write_data, bus.mem_size_and_sign);
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: legal range check, byte-lane arithmetic on a word array.
  task automatic model(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size,
                       output logic [31:0] ed, output logic ee, output int ew);
    int          sh;
    logic [31:0] mask;
    int          idx;
    ed = 32'h0; ee = 1'b0; ew = 0;
    idx = int'(addr / 4);
    if (addr > 32'(4 * DEPTH - 4)) begin
      ee = 1'b1;
    end else if (is_d && we) begin
      ew = 1;
      if (size == STORE_BYTE) begin
        sh = 8 * int'(addr % 4);        mask = 32'h0000_00FF << sh;
      end else if (size == STORE_HALF) begin
        sh = 16 * int'((addr % 4) / 2); mask = 32'h0000_FFFF << sh;
      end else begin
        sh = 0;                         mask = 32'hFFFF_FFFF;
      end
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
    end else begin
      ed = ref_mem[idx];
    end
  endtask

  task automatic single(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size, input string tag);
    logic [31:0] ed;
    logic        ee;
    int          ew;
    int          we0;
    model(is_d, we, addr, wdata, size, ed, ee, ew);
    if (is_d) begin
      bus.d_req_valid = 1'b1; bus.d_we = we; bus.d_addr = addr;
      bus.d_wdata = wdata; bus.d_size = size;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_addr = addr;
    end
    #1;
    chk({tag, "_ready"}, is_d ? bus.d_req_ready : bus.if_req_ready, 32'd1);
    we0 = we_cnt;
    tick();
    bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
    chk({tag, "_early"}, {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
    tick();
    chk({tag, "_vld"}, {bus.if_rsp_valid, bus.d_rsp_valid}, is_d ? 32'd1 : 32'd2);
    chk({tag, "_data"}, is_d ? bus.d_rsp_data : bus.if_rsp_data, ed);
    chk({tag, "_err"}, is_d ? bus.d_rsp_err : bus.if_rsp_err, {31'd0, ee});
    tick();
    chk({tag, "_wecnt"}, we_cnt - we0, ew);
  endtask

  initial begin
    logic [31:0] ed, addr, wdata, hold;
    logic        ee;
    int          ew, we0, mism;
    bit          is_d, we, exp_d;
    logic [2:0]  size;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = bg(i);
    bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_rsp_ready = 1'b1;
    bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.d_size = LOAD_WORD; bus.d_rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1; bus.d_req_valid = 1'b1;
    #1;
    chk("rst_if_ready", bus.if_req_ready, 32'd0);
    chk("rst_d_ready", bus.d_req_ready, 32'd0);
    chk("rst_rsp_valid", {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
    chk("rst_we", bus.mem_write_enable, 32'd0);
    chk("rst_addr", bus.mem_read_address, 32'd0);
    chk("rst_wdata", bus.mem_write_data, 32'd0);
    chk("rst_rsp_data", bus.d_rsp_data, 32'd0);
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    tick();
    reset = 1'b0;

    single(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, STORE_WORD, "r030_st");
    single(1'b0, 1'b0, 32'h10, 32'h0, LOAD_WORD, "r030_f");
    chk("r030_ram", ram[4], 32'hDEAD_BEEF);
    single(1'b1, 1'b1, 32'h21, 32'h0000_00AB, STORE_BYTE, "sb");
    single(1'b1, 1'b1, 32'h26, 32'h0000_C0DE, STORE_HALF, "sh");
    single(1'b1, 1'b0, 32'h20, 32'h0, LOAD_WORD, "ld20");
    single(1'b1, 1'b0, 32'hFFC, 32'h0, LOAD_WORD, "bound_ok");
    single(1'b1, 1'b1, 32'hFFD, 32'h55, STORE_BYTE, "bound_ffd");
    single(1'b1, 1'b1, 32'h1000, 32'hAB, STORE_BYTE, "r033");
    single(1'b0, 1'b0, 32'h1000, 32'h0, LOAD_WORD, "fetch_oob");

    // Fresh reset so last_grant is fetch and data wins the first conflict.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model(1'b1, 1'b1, 32'h20, 32'h1234_5678, STORE_WORD, ed, ee, ew);
    bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20;
    bus.d_wdata = 32'h1234_5678; bus.d_size = STORE_WORD;
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h20;
    #1;
    chk("r031_grant", {bus.d_req_ready, bus.if_req_ready}, 32'd2);
    tick();
    bus.d_req_valid = 1'b0;
    tick();
    chk("r031_ack_vld", bus.d_rsp_valid, 32'd1);
    chk("r031_ack_data", bus.d_rsp_data, 32'd0);
    tick();
    chk("r031_f_ready", bus.if_req_ready, 32'd1);
    tick();
    bus.if_req_valid = 1'b0;
    tick();
    chk("r031_f_vld", bus.if_rsp_valid, 32'd1);
    chk("r031_f_data", bus.if_rsp_data, 32'h1234_5678);
    tick();

    bus.d_we = 1'b0; bus.d_size = LOAD_WORD;
    bus.d_req_valid = 1'b1; bus.if_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.d_addr  = 32'(4 * $urandom_range(0, DEPTH - 1));
      bus.if_addr = 32'(4 * $urandom_range(0, DEPTH - 1));
      #1;
      exp_d = (k % 2 == 0);
      chk("r032_grant", {bus.d_req_ready, bus.if_req_ready}, exp_d ? 32'd2 : 32'd1);
      model(exp_d, 1'b0, exp_d ? bus.d_addr : bus.if_addr, 32'h0, LOAD_WORD, ed, ee, ew);
      tick();
      tick();
      chk("r032_rsp", {bus.if_rsp_valid, bus.d_rsp_valid}, exp_d ? 32'd1 : 32'd2);
      chk("r032_data", exp_d ? bus.d_rsp_data : bus.if_rsp_data, ed);
      tick();
    end
    bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;

    model(1'b1, 1'b1, 32'h30, 32'h7777_1111, STORE_WORD, ed, ee, ew);
    bus.d_rsp_ready = 1'b0;
    bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30;
    bus.d_wdata = 32'h7777_1111; bus.d_size = STORE_WORD;
    we0 = we_cnt;
    tick();
    bus.d_req_valid = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h30;
    tick();
    hold = bus.d_rsp_data;
    for (int k = 0; k < 10; k++) begin
      chk("r034_vld", bus.d_rsp_valid, 32'd1);
      chk("r034_data", bus.d_rsp_data, 32'd0);
      chk("r034_stable", bus.d_rsp_data, hold);
      chk("r034_if_ready", bus.if_req_ready, 32'd0);
      chk("r034_we", bus.mem_write_enable, 32'd0);
      tick();
    end
    chk("r034_we_once", we_cnt - we0, 32'd1);
    bus.d_rsp_ready = 1'b1;
    tick();
    chk("r034_idle", bus.if_req_ready, 32'd1);
    tick();
    bus.if_req_valid = 1'b0;
    tick();
    chk("r034_f_data", bus.if_rsp_data, 32'h7777_1111);
    tick();

    bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80;
    bus.d_wdata = 32'hCAFE_F00D; bus.d_size = STORE_WORD;
    #1;
    chk("r035_ready", bus.d_req_ready, 32'd1);
    we0 = we_cnt;
    tick();
    bus.d_req_valid = 1'b0;
    chk("r035_access_we", bus.mem_write_enable, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("r035_rsp_vld", {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
    chk("r035_we_off", bus.mem_write_enable, 32'd0);
    tick();
    reset = 1'b0;
    chk("r035_no_write", we_cnt - we0, 32'd0);
    chk("r035_mem", ram[32], ref_mem[32]);
    tick();
    chk("r035_rsp_after", {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      is_d = 1'($urandom % 2);
      we   = is_d && ($urandom % 2 == 1);
      if ($urandom % 4 == 0) addr = 32'(4 * DEPTH - 8) + 32'($urandom % 16);
      else                   addr = 32'($urandom % (4 * DEPTH));
      size  = we ? 3'($urandom % 3) : 3'($urandom % 8);
      wdata = $urandom;
      single(is_d, we, addr, wdata, size, "rand");
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_final", mism, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
